// File: rtl/adbus_align_tx.sv
// adbus_align_tx: transmit-side byte aligner. Takes a left-packed byte stream
// with a byte start address and emits doubleword-aligned beats with lane
// enables, shifting the payload into its address lanes. A misaligned transfer
// may need one extra "flush" beat built from the carried tail bytes.
module adbus_align_tx #(
    parameter int MAX_LEN = 256,
    parameter int LW      = $clog2(MAX_LEN) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   addr_in,
    input  logic [LW-1:0] len_in,
    output logic          busy,
    input  logic [63:0]   din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [31:0]   addrout,
    output logic [63:0]   dout,
    output logic [7:0]    bus_en_out,
    output logic          dout_last,
    output logic          dout_valid,
    input  logic          dout_ready
);
    localparam int PW = LW + 3;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

    state_t        state;
    logic [2:0]    off;
    logic [31:0]   base;
    logic [LW-1:0] len;
    logic [LW-1:0] in_left;
    logic [LW-1:0] last_k;
    logic [LW-1:0] k;
    logic          need_flush;
    logic [63:0]   carry;

    logic [LW:0]   in_n, out_n;
    logic          out_free, in_acc, fl_load, load;
    logic [5:0]    sh;
    logic [63:0]   raw, data_m;
    logic [7:0]    en;
    logic [PW-1:0] lo, hi;

    assign busy      = (state != IDLE);
    assign out_free  = !dout_valid || dout_ready;
    assign din_ready = (state == RUN) && (in_left != '0) && out_free;
    assign in_acc    = din_valid && din_ready;
    assign fl_load   = (state == FLUSH) && out_free;
    assign load      = in_acc || fl_load;
    assign sh        = {off, 3'b000};

    // Beat counts for a new request: input beats and address-aligned output beats.
    assign in_n  = ({1'b0, len_in} + (LW+1)'(7)) >> 3;
    assign out_n = ({1'b0, len_in} + (LW+1)'(addr_in[2:0]) + (LW+1)'(7)) >> 3;

    // Flush beat holds only the carried tail; off is never 0 there, so the
    // left shift is always below 64.
    assign raw = (state == FLUSH) ? (carry << (7'd64 - {1'b0, sh}))
                                  : 64'({carry, din} >> sh);

    assign lo = PW'(off);
    assign hi = lo + PW'(len);

    // Lane enables for beat k, and zeroing of disabled lanes.
    always_comb begin
        en     = '0;
        data_m = '0;
        for (int l = 0; l < 8; l++) begin
            en[7-l] = ((PW'({k, 3'b000}) + PW'(l)) >= lo) &&
                      ((PW'({k, 3'b000}) + PW'(l)) <  hi);
            data_m[63-8*l -: 8] = en[7-l] ? raw[63-8*l -: 8] : 8'h00;
        end
    end

    // Control FSM: request latch, input beat counting, flush and drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            off        <= '0;
            base       <= '0;
            len        <= '0;
            in_left    <= '0;
            last_k     <= '0;
            k          <= '0;
            need_flush <= 1'b0;
            carry      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && len_in != '0) begin
                        off        <= addr_in[2:0];
                        base       <= {addr_in[31:3], 3'b000};
                        len        <= len_in;
                        in_left    <= LW'(in_n);
                        last_k     <= LW'(out_n - (LW+1)'(1));
                        need_flush <= (out_n > in_n);
                        k          <= '0;
                        carry      <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (in_acc) begin
                        // Only the low off bytes spill into the next beat.
                        carry   <= din & ~({64{1'b1}} << sh);
                        k       <= k + LW'(1);
                        in_left <= in_left - LW'(1);
                        if (in_left == LW'(1))
                            state <= need_flush ? FLUSH : DRAIN;
                    end
                end
                FLUSH: begin
                    if (fl_load) begin
                        k     <= k + LW'(1);
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dout_valid && dout_ready && dout_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: loads a beat on input accept or flush, holds under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            bus_en_out <= '0;
            addrout    <= '0;
            dout_last  <= 1'b0;
            dout_valid <= 1'b0;
        end else if (load) begin
            dout       <= data_m;
            bus_en_out <= en;
            addrout    <= base + 32'({k, 3'b000});
            dout_last  <= (k == last_k);
            dout_valid <= 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adbus_align_tx.sv
// Directed bench for adbus_align_tx: hand-computed beats per transfer.
module tb_adbus_align_tx;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [31:0] addr_in = 0;
    logic [8:0]  len_in = 0;
    logic        busy;
    logic [63:0] din = 0;
    logic        din_valid = 0;
    logic        din_ready;
    logic [31:0] addrout;
    logic [63:0] dout;
    logic [7:0]  bus_en_out;
    logic        dout_last;
    logic        dout_valid;
    logic        dout_ready = 1;

    adbus_align_tx dut (
        .clk(clk), .rst(rst), .start(start), .addr_in(addr_in), .len_in(len_in),
        .busy(busy), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .addrout(addrout), .dout(dout), .bus_en_out(bus_en_out),
        .dout_last(dout_last), .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    logic [63:0] dq[4];
    logic [31:0] cap_a[$];
    logic [63:0] cap_d[$];
    logic [7:0]  cap_e[$];
    logic        cap_l[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Record every accepted output beat (sampled mid-cycle).
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            cap_a.push_back(addrout);
            cap_d.push_back(dout);
            cap_e.push_back(bus_en_out);
            cap_l.push_back(dout_last);
        end
    end

    task automatic clr_caps();
        cap_a.delete(); cap_d.delete(); cap_e.delete(); cap_l.delete();
    endtask

    task automatic chk_beat(input int idx, input logic [31:0] a, input logic [63:0] d,
                            input logic [7:0] e, input logic l);
        if (idx >= cap_a.size()) begin
            chk($sformatf("b%0d_missing", idx), cap_a.size(), idx + 1);
        end else begin
            chk($sformatf("b%0d_addr", idx), cap_a[idx], a);
            chk($sformatf("b%0d_data", idx), cap_d[idx], d);
            chk($sformatf("b%0d_en", idx), cap_e[idx], e);
            chk($sformatf("b%0d_last", idx), cap_l[idx], l);
        end
    endtask

    // Issue a request and feed n beats from dq; optionally pulse start mid-transfer.
    task automatic run_xfer(input logic [31:0] a, input logic [8:0] l, input int n, input bit inj);
        int  i, cyc;
        logic acc;
        @(posedge clk); #1;
        addr_in = a; len_in = l; start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("busy_up", busy, 1);
        i = 0; cyc = 0; din = dq[0]; din_valid = 1;
        while (i < n && cyc < 200) begin
            @(negedge clk); acc = din_ready;
            @(posedge clk); #1; cyc++;
            start = 0;
            if (acc) begin
                i++;
                if (i < n) din = dq[i];
                else begin din = 0; din_valid = 0; end
                if (inj && i == 1) begin
                    start = 1; addr_in = 32'hDEAD_0005; len_in = 9'd5;
                end
            end
        end
        start = 0; din_valid = 0;
        chk("feed_beats", i, n);
        @(negedge clk);
        chk("drdy_post_feed", din_ready, 0);
        cyc = 0;
        while (busy && cyc < 200) begin @(posedge clk); cyc++; end
        #1;
        chk("busy_done", busy, 0);
        repeat (2) @(posedge clk);
    endtask

    logic [63:0] held_d;
    logic [31:0] held_a;
    int c;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_drdy", din_ready, 0);
        chk("rst_vld", dout_valid, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_addr", addrout, 0);
        chk("rst_dout", dout, 0);
        chk("rst_en", bus_en_out, 0);
        @(posedge clk); #1; rst = 0;

        // Aligned, with a start pulse injected while busy.
        clr_caps();
        dq[0] = 64'h1122_3344_5566_7788; dq[1] = 64'h99AA_BBCC_DDEE_FF00;
        run_xfer(32'h1000, 9'd16, 2, 1);
        chk("al_nbeats", cap_a.size(), 2);
        chk_beat(0, 32'h1000, 64'h1122_3344_5566_7788, 8'hFF, 0);
        chk_beat(1, 32'h1008, 64'h99AA_BBCC_DDEE_FF00, 8'hFF, 1);

        // Short misaligned.
        clr_caps();
        dq[0] = 64'hAABB_0000_0000_0000;
        run_xfer(32'h1003, 9'd2, 1, 0);
        chk("sm_nbeats", cap_a.size(), 1);
        chk_beat(0, 32'h1000, 64'h0000_00AA_BB00_0000, 8'h18, 1);

        // Flush beat.
        clr_caps();
        dq[0] = 64'h0102_0304_0506_0708;
        run_xfer(32'h1005, 9'd8, 1, 0);
        chk("fl_nbeats", cap_a.size(), 2);
        chk_beat(0, 32'h1000, 64'h0000_0000_0001_0203, 8'h07, 0);
        chk_beat(1, 32'h1008, 64'h0405_0607_0800_0000, 8'hF8, 1);

        // Backpressure mid-burst.
        clr_caps();
        dq[0] = 64'h0001_0203_0405_0607;
        dq[1] = 64'h0809_0A0B_0C0D_0E0F;
        dq[2] = 64'h1011_1213_1415_1617;
        fork
            run_xfer(32'h2002, 9'd24, 3, 0);
            begin
                c = 0;
                while (cap_a.size() < 1 && c < 100) begin @(negedge clk); c++; end
                @(posedge clk); #1; dout_ready = 0;
                @(negedge clk);
                held_d = dout; held_a = addrout;
                chk("st_vld", dout_valid, 1);
                chk("st_drdy0", din_ready, 0);
                repeat (2) begin
                    @(negedge clk);
                    chk("st_drdy", din_ready, 0);
                    chk("st_hold_d", dout, held_d);
                    chk("st_hold_a", addrout, held_a);
                end
                @(posedge clk); #1; dout_ready = 1;
            end
        join
        chk("bp_nbeats", cap_a.size(), 4);
        chk_beat(0, 32'h2000, 64'h0000_0001_0203_0405, 8'h3F, 0);
        chk_beat(1, 32'h2008, 64'h0607_0809_0A0B_0C0D, 8'hFF, 0);
        chk_beat(2, 32'h2010, 64'h0E0F_1011_1213_1415, 8'hFF, 0);
        chk_beat(3, 32'h2018, 64'h1617_0000_0000_0000, 8'hC0, 1);

        // Abort a 32-byte transfer after its first output beat.
        clr_caps();
        dq[0] = 64'h5555_6666_7777_8888;
        @(posedge clk); #1; addr_in = 32'h1000; len_in = 9'd32; start = 1;
        @(posedge clk); #1; start = 0; din = dq[0]; din_valid = 1;
        c = 0;
        while (cap_a.size() < 1 && c < 50) begin @(negedge clk); c++; end
        chk("ab_first_seen", cap_a.size() >= 1, 1);
        chk_beat(0, 32'h1000, 64'h5555_6666_7777_8888, 8'hFF, 0);
        @(posedge clk); #1; rst = 1; din_valid = 0; din = 0;
        #1;
        chk("ab_busy", busy, 0);
        chk("ab_drdy", din_ready, 0);
        chk("ab_vld", dout_valid, 0);
        chk("ab_last", dout_last, 0);
        chk("ab_addr", addrout, 0);
        chk("ab_dout", dout, 0);
        chk("ab_en", bus_en_out, 0);
        repeat (2) @(posedge clk); #1; rst = 0;
        clr_caps();
        dq[0] = 64'hCAFE_F00D_DEAD_BEEF;
        run_xfer(32'h3000, 9'd8, 1, 0);
        chk("rs_nbeats", cap_a.size(), 1);
        chk_beat(0, 32'h3000, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, 1);

        // Ignored: zero-length start and din_valid while idle.
        clr_caps();
        @(posedge clk); #1; addr_in = 32'h10; len_in = 9'd0; start = 1;
        @(posedge clk); #1; start = 0; din = 64'h1234; din_valid = 1;
        repeat (3) begin
            @(negedge clk);
            chk("z_busy", busy, 0);
            chk("z_drdy", din_ready, 0);
        end
        @(posedge clk); #1; din_valid = 0;
        chk("z_nbeats", cap_a.size(), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/adbus_align_tx.md
Name: adbus_align_tx

Overview:
- Transmit-side byte aligner for the SRIO payload path; the inverse of the receive-side lane normaliser.
- Accepts a byte-addressed transfer: start address, byte length, and a left-packed 64-bit data stream.
- Emits doubleword-aligned beats with the byte-enable pattern that SRIO expects: 8-byte-aligned address, data shifted into the correct lanes, partial enables on the first and last beats.
- Sits between the local payload source and the SRIO request formatter.

Parameters:
- MAX_LEN, 256, maximum transfer length in bytes; the len_in width is clog2(MAX_LEN)+1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- addr_in  input  32  byte start address.
- len_in  input  9  byte count, 1..MAX_LEN.
- busy  output  1  high from an accepted start until the last output beat is accepted.
- din  input  64  packed payload; byte 0 of the beat is din[63:56]; the last beat is left-packed.
- din_valid  input  1  payload beat valid.
- din_ready  output  1  payload beat accepted when din_valid && din_ready.
- addrout  output  32  beat address, bits [2:0] always 0.
- dout  output  64  aligned data; lane L = dout[63-8L -: 8].
- bus_en_out  output  8  lane enables; bit (7-L) enables lane L.
- dout_last  output  1  marks the final beat of the transfer.
- dout_valid  output  1  output beat valid.
- dout_ready  input  1  downstream accept.

Behaviour:
- Reset values: busy=0, din_ready=0, dout_valid=0, dout_last=0, addrout=0, dout=0, bus_en_out=0. State is IDLE. Counters and carry register are cleared.
- States:
  - IDLE: start with len_in!=0 latches off=addr_in[2:0], base={addr_in[31:3],3'b0}, len, in_left=ceil(len/8), out_left=ceil((off+len)/8), beat index k=0, carry=0, then goes to RUN. start with len_in=0 is ignored.
  - RUN: din_ready = (in_left!=0) && (!dout_valid || dout_ready). On each input accept, load the output register:
    - dout = ({carry,din} >> 8*off)[63:0], where carry holds the previous beat's last off bytes.
    - carry <= low 8*off bits of din.
    - addrout = base + 8k; k++; in_left--.
    - Leave RUN when in_left reaches 0: go to FLUSH if out_left exceeds the number of input beats, otherwise go to DRAIN.
  - FLUSH: when the output register is free, load dout = carry << (64-8*off), addrout = base+8k, and set dout_last. Then go to DRAIN.
  - DRAIN: wait for the final beat to be accepted, then return to IDLE and drop busy.
- Byte enables:
  - Lane L of beat k is enabled iff off <= 8k+L < off+len.
  - Disabled lanes carry zero data.
- dout_last is asserted on beat k = out_left_initial-1.
- Output handshake:
  - The output register holds its value while dout_valid && !dout_ready.
  - dout_valid clears on accept unless a new beat loads in the same cycle; back-to-back beats sustain one beat per clock.
- Latency: each output beat is registered one clock after its input accept.
- din_valid outside RUN is ignored; no data is consumed.
- start while busy is ignored.
- A mid-transfer reset aborts the transfer and returns every output to its reset value. No partial beat is emitted after reset.
- Address arithmetic is 32-bit wrap-around.
- Length above MAX_LEN is undefined; verification must not drive it.

Test Plan:
- Aligned: addr 0x1000, len 16, two input beats A, B -> two beats at 0x1000/0x1008, bus_en 0xFF/0xFF, dout A/B unchanged, last on beat 2.
- Short misaligned: addr 0x1003, len 2, din 0xAABB_0000_0000_0000 -> one beat at 0x1000, bus_en 0x18, dout 0x0000_00AA_BB00_0000, last=1.
- Flush beat: addr 0x1005, len 8, din 0x0102030405060708 -> two beats:
  - beat 1 at 0x1000, bus_en 0x07, dout 0x0000_0000_0001_0203.
  - beat 2 at 0x1008, bus_en 0xF8, dout 0x0405_0607_0800_0000, last=1.
  - din_ready stays low during FLUSH.
- Backpressure: len 24 at addr 0x2002 with dout_ready low for 3 cycles mid-burst -> outputs held stable, din_ready=0 while stalled, 4 beats total, bus_en 0x3F,0xFF,0xFF,0xC0.
- Reset/abort: assert rst after the first output beat of a 32-byte transfer -> all outputs 0 immediately. A new start at 0x3000, len 8 then completes correctly with one beat, bus_en 0xFF.
- Ignored inputs: start pulse while busy, and start with len_in=0 in IDLE -> no state change, beat count unchanged.
